// File: rtl/msg_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module   : msg_stream_sched
//  Purpose  : Walks a combinational 8-bit ASCII message ROM and streams its
//             characters over a valid/ready handshake. Three modes: one word
//             picked by index, the whole message once, or the whole message
//             in a loop. A programmable gap is inserted between characters.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start, stop           - request pulse / abort
//             mode, word_sel,       - control, latched on an accepted start
//             rate_div
//             rom_addr, rom_data    - ROM address out, data in (same cycle)
//             out_char, out_valid,  - character stream
//             out_ready
//             busy, done, err       - status (done/err are one-cycle pulses)
//             word_idx              - index of the word being emitted
//  Revision : 1.0 - initial release
// ============================================================================
module msg_stream_sched #(
   parameter int         MSG_LEN   = 51,
   parameter int         ADDR_W    = 6,
   parameter int         NUM_WORDS = 7,
   parameter logic [7:0] SEP       = 8'h20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [2:0]        word_sel,
   input  logic [7:0]        rate_div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        out_char,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        word_idx
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(MSG_LEN - 1);
   localparam logic [3:0]        c_num_words = 4'(NUM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEEK = 3'd1,
      S_PACE = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state,  w_nxt_state;
   logic [1:0]        r_mode,   w_nxt_mode;
   logic [2:0]        r_wsel,   w_nxt_wsel;
   logic [7:0]        r_rate,   w_nxt_rate;
   logic [7:0]        r_cnt,    w_nxt_cnt;
   logic [ADDR_W-1:0] w_nxt_addr;
   logic [2:0]        w_nxt_widx;
   logic [7:0]        w_nxt_char;
   logic              w_nxt_valid;
   logic              w_nxt_err;

   logic              w_is_sep;
   logic [2:0]        w_widx_inc;
   logic              w_at_last;

   assign w_is_sep   = (rom_data == SEP);
   assign w_widx_inc = word_idx + 3'd1;
   assign w_at_last  = (rom_addr == c_last_addr);

   assign busy = (r_state == S_SEEK) || (r_state == S_PACE) || (r_state == S_EMIT);
   assign done = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_mode    <= 2'd0;
         r_wsel    <= 3'd0;
         r_rate    <= 8'd0;
         r_cnt     <= 8'd0;
         rom_addr  <= '0;
         word_idx  <= 3'd0;
         out_char  <= 8'h00;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_mode    <= w_nxt_mode;
         r_wsel    <= w_nxt_wsel;
         r_rate    <= w_nxt_rate;
         r_cnt     <= w_nxt_cnt;
         rom_addr  <= w_nxt_addr;
         word_idx  <= w_nxt_widx;
         out_char  <= w_nxt_char;
         out_valid <= w_nxt_valid;
         err       <= w_nxt_err;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_mode  = r_mode;
      w_nxt_wsel  = r_wsel;
      w_nxt_rate  = r_rate;
      w_nxt_cnt   = r_cnt;
      w_nxt_addr  = rom_addr;
      w_nxt_widx  = word_idx;
      w_nxt_char  = out_char;
      w_nxt_valid = out_valid;
      w_nxt_err   = 1'b0;

      if (stop) begin
         // Abort outranks everything, including a simultaneous start.
         w_nxt_state = S_IDLE;
         w_nxt_valid = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_nxt_mode = mode;
                  w_nxt_wsel = word_sel;
                  w_nxt_rate = rate_div;
                  w_nxt_cnt  = rate_div;
                  w_nxt_addr = '0;
                  w_nxt_widx = 3'd0;
                  if ((mode == 2'd3) || ((mode == 2'd0) && ({1'b0, word_sel} >= c_num_words))) begin
                     w_nxt_err = 1'b1;
                  end else if ((mode == 2'd0) && (word_sel != 3'd0)) begin
                     w_nxt_state = S_SEEK;
                  end else begin
                     w_nxt_state = S_PACE;
                  end
               end
            end

            S_SEEK: begin
               // Count separators until the requested word begins just past one.
               if (w_is_sep && (w_widx_inc == r_wsel)) begin
                  w_nxt_widx  = w_widx_inc;
                  w_nxt_addr  = rom_addr + 1'b1;
                  w_nxt_cnt   = r_rate;
                  w_nxt_state = S_PACE;
               end else if (w_at_last) begin
                  w_nxt_err   = 1'b1;
                  w_nxt_state = S_IDLE;
               end else begin
                  if (w_is_sep) begin
                     w_nxt_widx = w_widx_inc;
                  end
                  w_nxt_addr = rom_addr + 1'b1;
               end
            end

            S_PACE: begin
               if (r_cnt != 8'd0) begin
                  w_nxt_cnt = r_cnt - 8'd1;
               end else if ((r_mode == 2'd0) && w_is_sep) begin
                  // End of the selected word; the separator itself is not sent.
                  w_nxt_state = S_DONE;
               end else begin
                  w_nxt_char  = rom_data;
                  w_nxt_valid = 1'b1;
                  w_nxt_state = S_EMIT;
               end
            end

            S_EMIT: begin
               if (out_valid && out_ready) begin
                  w_nxt_valid = 1'b0;
                  if (w_at_last) begin
                     if (r_mode == 2'd2) begin
                        w_nxt_addr  = '0;
                        w_nxt_widx  = 3'd0;
                        w_nxt_cnt   = r_rate;
                        w_nxt_state = S_PACE;
                     end else begin
                        w_nxt_state = S_DONE;
                     end
                  end else begin
                     w_nxt_addr = rom_addr + 1'b1;
                     if ((out_char == SEP) && (r_mode != 2'd0)) begin
                        w_nxt_widx = w_widx_inc;
                     end
                     w_nxt_cnt   = r_rate;
                     w_nxt_state = S_PACE;
                  end
               end
            end

            S_DONE: begin
               w_nxt_state = S_IDLE;
            end

            default: begin
               w_nxt_state = S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msg_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msg_stream_sched
//  Purpose  : Self-checking bench for msg_stream_sched. Supplies a 51-byte
//             message ROM, runs a table of start requests and checks the
//             emitted stream, then exercises backpressure, looping with
//             stop, start/stop collisions and an asynchronous mid-run reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msg_stream_sched;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [1:0] mode;
   logic [2:0] word_sel;
   logic [7:0] rate_div;
   logic [5:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] word_idx;

   logic [7:0] rom [0:50];
   string      msg = "Tarapacas Tacana Putre Arica Lluta Parinacota Agua ";

   int n_vec  = 0;
   int n_fail = 0;

   msg_stream_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .word_sel  (word_sel),
      .rate_div  (rate_div),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_char  (out_char),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .word_idx  (word_idx)
   );

   assign rom_data = (rom_addr <= 6'd50) ? rom[rom_addr] : 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int mode;
      int ws;
      int rate;
      int n;      // characters expected
      int first;  // first character
      int last;   // last character
      int sa;     // ROM address of first character
      int fc;     // cycle of first character (start cycle = 0)
      int dc;     // cycle of done pulse, -1 if none
      int err;    // 1 if err pulse expected at cycle 1
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int         nch     = 0;
      int         first_c = -1;
      int         prev_c  = -1;
      int         done_c  = -1;
      int         err_c   = -1;
      logic [7:0] first_ch = 8'h00;
      logic [7:0] last_ch  = 8'h00;
      logic [2:0] ew;
      mode      = 2'(v.mode);
      word_sel  = 3'(v.ws);
      rate_div  = 8'(v.rate);
      out_ready = 1'b1;
      ew = (v.mode == 0) ? 3'(v.ws) : 3'd0;
      pulse_start();
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if (out_valid) begin
            if (nch < v.n) begin
               chk($sformatf("v%0d_char%0d", id, nch), 32'(out_char), 32'(rom[v.sa + nch]));
            end else begin
               chk($sformatf("v%0d_extra_char", id), 32'(nch), 32'(v.n - 1));
            end
            chk($sformatf("v%0d_widx%0d", id, nch), 32'(word_idx), 32'(ew));
            if (nch > 0) begin
               chk($sformatf("v%0d_gap%0d", id, nch), cyc - prev_c, v.rate + 2);
            end else begin
               first_c  = cyc;
               first_ch = out_char;
            end
            if ((v.mode != 0) && (out_char == 8'h20)) ew = ew + 3'd1;
            last_ch = out_char;
            prev_c  = cyc;
            nch++;
         end
         if (done && (done_c < 0)) done_c = cyc;
         if (err && (err_c < 0)) err_c = cyc;
         if ((done_c >= 0) && (cyc == done_c + 1)) begin
            chk($sformatf("v%0d_busy_after_done", id), 32'(busy), 32'd0);
            chk($sformatf("v%0d_done_width", id), 32'(done), 32'd0);
            break;
         end
         if ((v.err != 0) && (cyc == 6)) begin
            chk($sformatf("v%0d_busy_on_err", id), 32'(busy), 32'd0);
            chk($sformatf("v%0d_err_width", id), 32'(err), 32'd0);
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_nchars", id), nch, v.n);
      if (v.n > 0) begin
         chk($sformatf("v%0d_first_char", id), 32'(first_ch), v.first);
         chk($sformatf("v%0d_last_char", id), 32'(last_ch), v.last);
         chk($sformatf("v%0d_first_cycle", id), first_c, v.fc);
      end
      chk($sformatf("v%0d_done_cycle", id), done_c, v.dc);
      chk($sformatf("v%0d_err_cycle", id), err_c, (v.err != 0) ? 1 : -1);
      @(negedge clk);
   endtask

   initial begin
      int         nch;
      int         prev_c;
      int         saw_done;
      logic [2:0] ew;

      for (int i = 0; i < 51; i++) rom[i] = msg[i];

      //            mode ws rate  n  first last  sa  fc   dc  err
      vt[0] = '{1, 0, 0, 51, 'h54, 'h20,  0,  2, 103, 0};
      vt[1] = '{0, 1, 0,  6, 'h54, 'h61, 10, 12,  24, 0};
      vt[2] = '{0, 6, 0,  4, 'h41, 'h61, 46, 48,  56, 0};
      vt[3] = '{0, 7, 0,  0,    0,    0,  0, -1,  -1, 1};
      vt[4] = '{3, 0, 0,  0,    0,    0,  0, -1,  -1, 1};
      vt[5] = '{0, 0, 2,  9, 'h54, 'h73,  0,  4,  40, 0};
      vt[6] = '{1, 0, 1, 51, 'h54, 'h20,  0,  3, 154, 0};
      vt[7] = '{0, 3, 0,  5, 'h41, 'h61, 23, 25,  35, 0};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
      word_sel = 3'd0; rate_div = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_out_char", 32'(out_char), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_word_idx", 32'(word_idx), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vt[i], i);

      // Backpressure on the first character; a start while busy is ignored.
      mode = 2'd1; rate_div = 8'd0; out_ready = 1'b0;
      pulse_start();
      @(negedge clk);                       // cycle 2
      mode = 2'd3; start = 1'b1;            // would err if honoured
      for (int c = 2; c <= 6; c++) begin
         chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp_char_c%0d", c), 32'(out_char), 32'h54);
         chk($sformatf("bp_err_c%0d", c), 32'(err), 32'd0);
         @(negedge clk);
         start = 1'b0;
      end
      out_ready = 1'b1;                     // cycle 7
      chk("bp_hold_c7", 32'(out_char), 32'h54);
      @(negedge clk);
      chk("bp_pace_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_char", 32'(out_char), 32'h61);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("bp_stop_busy", 32'(busy), 32'd0);
      chk("bp_stop_valid", 32'(out_valid), 32'd0);

      // stop together with start from IDLE: stop wins.
      mode = 2'd1; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("ss_busy_later", 32'(busy), 32'd0);
      chk("ss_valid_later", 32'(out_valid), 32'd0);

      // Loop mode with rate 3, wrap across the end of the message, then stop.
      mode = 2'd2; rate_div = 8'd3; out_ready = 1'b1;
      nch = 0; prev_c = -1; ew = 3'd0;
      pulse_start();
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if (out_valid) begin
            chk($sformatf("loop_char%0d", nch), 32'(out_char), 32'(rom[nch % 51]));
            chk($sformatf("loop_widx%0d", nch), 32'(word_idx), 32'(ew));
            if (nch > 0) chk($sformatf("loop_gap%0d", nch), cyc - prev_c, 5);
            if ((nch % 51) == 50) ew = 3'd0;
            else if (out_char == 8'h20) ew = ew + 3'd1;
            prev_c = cyc;
            nch++;
            if (nch == 56) break;
         end
         @(negedge clk);
      end
      chk("loop_nchars", nch, 56);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("loop_stop_valid", 32'(out_valid), 32'd0);
      chk("loop_stop_busy", 32'(busy), 32'd0);
      saw_done = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) saw_done = 1;
         @(negedge clk);
      end
      chk("loop_stop_no_done", saw_done, 0);

      // Asynchronous reset while a character is held in EMIT.
      mode = 2'd1; rate_div = 8'd0; out_ready = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);            // cycle 6: third char on the bus
      out_ready = 1'b0;
      chk("ar_pre_char", 32'(out_char), 32'h72);
      chk("ar_pre_addr", 32'(rom_addr), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_rom_addr", 32'(rom_addr), 32'd0);
      chk("ar_out_char", 32'(out_char), 32'd0);
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_err", 32'(err), 32'd0);
      chk("ar_word_idx", 32'(word_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      pulse_start();
      chk("ar_restart_addr", 32'(rom_addr), 32'd0);
      chk("ar_restart_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("ar_restart_valid", 32'(out_valid), 32'd1);
      chk("ar_restart_char", 32'(out_char), 32'h54);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
